// File: rtl/tdp_ram_port_adapter.sv
// tdp_ram_port_adapter: valid/ready front end for one port of a read-first,
// single-clock true dual-port RAM with a fixed read latency of 1 or 2 cycles.
// Read data lands in a credit-protected first-word-fall-through response FIFO.
// Optional macro TDP_RAM_PORT_ADAPTER_WRITE_ACK_EN: writes also consume a
// credit and return the old (read-first) contents as a response.
module tdp_ram_port_adapter #(
  parameter int unsigned RAM_WIDTH       = 18,
  parameter int unsigned RAM_DEPTH       = 1024,
  parameter string       RAM_PERFORMANCE = "HIGH_PERFORMANCE",
  parameter int unsigned RSP_DEPTH       = 4,
  // bits needed to hold RAM_DEPTH-1
  localparam int unsigned ADDR_W         = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [RAM_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RAM_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  output logic                 ram_en,
  output logic                 ram_regce,
  output logic                 ram_rst,
  input  logic [RAM_WIDTH-1:0] ram_dout
);

  localparam int unsigned LAT   = (RAM_PERFORMANCE == "LOW_LATENCY") ? 1 : 2;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1) + 1;
  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // The FIFO must hold every read that can be in the RAM pipe plus one.
  if (RSP_DEPTH < LAT + 1) begin : g_depth_check
    $error("tdp_ram_port_adapter: RSP_DEPTH must be at least LAT+1");
  end

  logic [CNT_W-1:0]     credit;
  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     fifo_count;
  logic                 accept;
  logic                 tag_set;
  logic [LAT:0]         tag_chain;
  logic [LAT-1:0]       tag_q;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 full;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [RAM_WIDTH-1:0] fifo_mem [RSP_DEPTH];

  // Credit left for new responses and the request handshake.
  always_comb begin
    credit = CNT_W'(RSP_DEPTH) - fifo_count - inflight;
`ifdef TDP_RAM_PORT_ADAPTER_WRITE_ACK_EN
    req_ready = !rst && (credit != '0);
    accept    = req_valid && req_ready;
    tag_set   = accept;
`else
    req_ready = !rst && (req_we || (credit != '0));
    accept    = req_valid && req_ready;
    tag_set   = accept && !req_we;
`endif
  end

  // Issue straight through to the RAM port; address/data held at 0 in reset.
  always_comb begin
    ram_en   = accept;
    ram_we   = accept && req_we;
    ram_addr = rst ? '0 : req_addr;
    ram_din  = rst ? '0 : req_wdata;
    ram_rst  = rst;
  end

  // tag_chain[k] marks a response-producing access accepted k cycles ago.
  always_comb begin
    tag_chain = {tag_q, tag_set};
    push      = tag_q[LAT-1];
    ram_regce = (LAT == 2) ? tag_q[0] : 1'b0;
  end

  // Tag pipeline tracking the fixed RAM read latency.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_chain[LAT-1:0];
    end
  end

  // Accesses issued to the RAM whose data has not yet reached the FIFO.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({tag_set, push})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // FIFO status and fall-through head.
  always_comb begin
    empty     = (fifo_count == '0);
    full      = (fifo_count == CNT_W'(RSP_DEPTH));
    pop       = !empty && rsp_ready;
    rsp_valid = !empty;
    rsp_rdata = empty ? '0 : fifo_mem[rd_ptr];
  end

  // FIFO pointers and occupancy; pointers wrap at RSP_DEPTH.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; data words need no reset since rsp_rdata is gated by empty.
  always_ff @(posedge clka) begin
    if (push) begin
      fifo_mem[wr_ptr] <= ram_dout;
    end
  end

  // Credits make a push into a full FIFO impossible.
  no_overflow: assert property (@(posedge clka) disable iff (rst) !(push && full))
    else $error("tdp_ram_port_adapter: push into full response FIFO");

endmodule

// File: tb/tb_tdp_ram_port_adapter.sv
// Bench for tdp_ram_port_adapter: one HIGH_PERFORMANCE (port 0) and one
// LOW_LATENCY (port 1) instance, each with a behavioural read-first RAM.
// A queue-based model predicts handshake, RAM-port and response behaviour.
module tb_tdp_ram_port_adapter;

  localparam int unsigned W     = 18;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned RSP   = 4;
`ifdef TDP_RAM_PORT_ADAPTER_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic load_mem;
  always #5 clk = ~clk;

  logic          req_valid [2];
  logic          req_ready [2];
  logic          req_we    [2];
  logic [AW-1:0] req_addr  [2];
  logic [W-1:0]  req_wdata [2];
  logic          rsp_valid [2];
  logic          rsp_ready [2];
  logic [W-1:0]  rsp_rdata [2];
  logic [AW-1:0] ram_addr  [2];
  logic [W-1:0]  ram_din   [2];
  logic [W-1:0]  ram_dout  [2];
  logic          ram_we    [2];
  logic          ram_en    [2];
  logic          ram_regce [2];
  logic          ram_rst   [2];

  int checks   = 0;
  int failures = 0;

  tdp_ram_port_adapter #(
    .RAM_WIDTH(18), .RAM_DEPTH(1024), .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .RSP_DEPTH(4)
  ) u_hp (
    .clka(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_din(ram_din[0]), .ram_we(ram_we[0]), .ram_en(ram_en[0]),
    .ram_regce(ram_regce[0]), .ram_rst(ram_rst[0]), .ram_dout(ram_dout[0])
  );

  tdp_ram_port_adapter #(
    .RAM_WIDTH(18), .RAM_DEPTH(1024), .RAM_PERFORMANCE("LOW_LATENCY"), .RSP_DEPTH(4)
  ) u_ll (
    .clka(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_din(ram_din[1]), .ram_we(ram_we[1]), .ram_en(ram_en[1]),
    .ram_regce(ram_regce[1]), .ram_rst(ram_rst[1]), .ram_dout(ram_dout[1])
  );

  function automatic logic [W-1:0] pat(input int unsigned i);
    return W'((i * 32'd1237 + 32'd291) ^ 32'h15A5A);
  endfunction

  // Behavioural read-first RAMs (port 0 with output register)
  logic [W-1:0] mem0 [DEPTH];
  logic [W-1:0] mem1 [DEPTH];
  logic [W-1:0] lat0, reg0, lat1;
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem0[i] <= pat(i);
        mem1[i] <= pat(i);
      end
    end else begin
      if (ram_en[0]) begin
        lat0 <= mem0[ram_addr[0]];
        if (ram_we[0]) mem0[ram_addr[0]] <= ram_din[0];
      end
      if (ram_en[1]) begin
        lat1 <= mem1[ram_addr[1]];
        if (ram_we[1]) mem1[ram_addr[1]] <= ram_din[1];
      end
    end
    if (ram_rst[0]) reg0 <= '0;
    else if (ram_regce[0]) reg0 <= lat0;
  end
  assign ram_dout[0] = reg0;
  assign ram_dout[1] = lat1;

  // ---------------- model state ----------------
  logic [W-1:0] ref0 [DEPTH];
  logic [W-1:0] ref1 [DEPTH];
  logic [W-1:0] d0[$], d1[$], l0[$], l1[$];
  int           a0[$], a1[$];
  logic         prev_tag [2];
  int           ncyc = 0;

  task automatic chk(input int p, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL p%0d %s: got %0h expected %0h (t=%0t)", p, name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input int p, input string name);
    checks++;
    failures++;
    $display("FAIL p%0d %s: bound expired (t=%0t)", p, name, $time);
  endtask

  function automatic int q_size(input int p);
    return (p == 0) ? d0.size() : d1.size();
  endfunction
  function automatic int q_acc(input int p);
    return (p == 0) ? a0[0] : a1[0];
  endfunction
  function automatic logic [W-1:0] q_front(input int p);
    return (p == 0) ? d0[0] : d1[0];
  endfunction
  function automatic void q_push(input int p, input logic [W-1:0] v, input int c);
    if (p == 0) begin d0.push_back(v); a0.push_back(c); end
    else begin d1.push_back(v); a1.push_back(c); end
  endfunction
  function automatic void q_pop(input int p);
    if (p == 0) begin l0.push_back(d0.pop_front()); void'(a0.pop_front()); end
    else begin l1.push_back(d1.pop_front()); void'(a1.pop_front()); end
  endfunction
  function automatic void q_clear(input int p);
    if (p == 0) begin d0.delete(); a0.delete(); end
    else begin d1.delete(); a1.delete(); end
  endfunction
  function automatic logic [W-1:0] ref_rd(input int p, input logic [AW-1:0] a);
    return (p == 0) ? ref0[a] : ref1[a];
  endfunction
  function automatic void ref_wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] v);
    if (p == 0) ref0[a] = v;
    else ref1[a] = v;
  endfunction
  function automatic int log_size(input int p);
    return (p == 0) ? l0.size() : l1.size();
  endfunction
  function automatic logic [W-1:0] log_at(input int p, input int i);
    return (p == 0) ? l0[i] : l1[i];
  endfunction
  function automatic void log_clear(input int p);
    if (p == 0) l0.delete();
    else l1.delete();
  endfunction

  // One cycle of the model: outstanding responses in order, each visible
  // LAT+1 cycles after acceptance, credit = RSP minus outstanding responses.
  task automatic model_step(input int p);
    int           sz;
    int           lat;
    logic         exp_ready, exp_en, exp_valid, makes_rsp;
    sz  = q_size(p);
    lat = (p == 0) ? 2 : 1;
    if (rst) begin
      q_clear(p);
      prev_tag[p] = 1'b0;
      chk(p, "rst_req_ready", 32'(req_ready[p]), 32'd0);
      chk(p, "rst_ram_en", 32'(ram_en[p]), 32'd0);
      chk(p, "rst_rsp_valid", 32'(rsp_valid[p]), 32'd0);
    end else begin
      exp_ready = (req_we[p] && !WACK) ? 1'b1 : (sz < int'(RSP));
      exp_en    = req_valid[p] && exp_ready;
      chk(p, "req_ready", 32'(req_ready[p]), 32'(exp_ready));
      chk(p, "ram_en", 32'(ram_en[p]), 32'(exp_en));
      chk(p, "ram_we", 32'(ram_we[p]), 32'(exp_en && req_we[p]));
      if (exp_en) begin
        chk(p, "ram_addr", 32'(ram_addr[p]), 32'(req_addr[p]));
        chk(p, "ram_din", 32'(ram_din[p]), 32'(req_wdata[p]));
      end
      chk(p, "ram_regce", 32'(ram_regce[p]), (p == 0) ? 32'(prev_tag[p]) : 32'd0);
      exp_valid = 1'b0;
      if (sz > 0) exp_valid = (ncyc >= q_acc(p) + lat + 1);
      chk(p, "rsp_valid", 32'(rsp_valid[p]), 32'(exp_valid));
      if (rsp_valid[p] && sz > 0) begin
        chk(p, "rsp_rdata", 32'(rsp_rdata[p]), 32'(q_front(p)));
        if (rsp_ready[p]) q_pop(p);
      end
      makes_rsp = exp_en && (!req_we[p] || WACK);
      if (makes_rsp) q_push(p, ref_rd(p, req_addr[p]), ncyc);
      if (exp_en && req_we[p]) ref_wr(p, req_addr[p], req_wdata[p]);
      prev_tag[p] = makes_rsp;
    end
  endtask

  // Compare process: runs on every falling edge, away from the active edge
  always @(negedge clk) begin
    ncyc++;
    if (load_mem) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        ref0[i] = pat(i);
        ref1[i] = pat(i);
      end
    end
    model_step(0);
    model_step(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int p, input logic we, input logic [AW-1:0] a,
                      input logic [W-1:0] d, output int waits);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p]  = a;
    req_wdata[p] = d;
    waits = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready[p] === 1'b1) break;
      waits++;
      if (waits > 200) begin
        note_fail(p, "accept_timeout");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int p);
    req_valid[p] = 1'b0;
    req_we[p]    = 1'b0;
  endtask

  task automatic drain(input int p);
    int n;
    n = 0;
    while (q_size(p) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(p, "drain_outstanding", 32'(q_size(p)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_latency(input int p, input logic [AW-1:0] a,
                              input int exp_lat, input logic [W-1:0] exp_d);
    int w, k;
    send(p, 1'b0, a, '0, w);
    idle(p);
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid[p]) break;
    end
    chk(p, "t1_latency", 32'(k), 32'(exp_lat));
    chk(p, "t1_data", 32'(rsp_rdata[p]), 32'(exp_d));
    @(negedge clk);
    chk(p, "t1_single_cycle", 32'(rsp_valid[p]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int w, stall, hi;
    rst = 1'b1;
    load_mem = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_valid[p] = 1'b1;
      req_we[p]    = 1'b1;
      req_addr[p]  = AW'(5);
      req_wdata[p] = W'(3);
      rsp_ready[p] = 1'b1;
      prev_tag[p]  = 1'b0;
    end
    // reset values with a request pending
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      chk(p, "reset_req_ready", 32'(req_ready[p]), 32'd0);
      chk(p, "reset_ram_we", 32'(ram_we[p]), 32'd0);
      chk(p, "reset_ram_addr", 32'(ram_addr[p]), 32'd0);
      chk(p, "reset_ram_din", 32'(ram_din[p]), 32'd0);
      chk(p, "reset_ram_regce", 32'(ram_regce[p]), 32'd0);
      chk(p, "reset_ram_rst", 32'(ram_rst[p]), 32'd1);
      chk(p, "reset_rsp_rdata", 32'(rsp_rdata[p]), 32'd0);
    end
    @(posedge clk);
    #1;
    idle(0);
    idle(1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    load_mem = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: write then read, latency LAT+1 and single-cycle response
    send(0, 1'b1, AW'(5), W'(18'h2A5A5), w);
    idle(0);
    drain(0);
    read_latency(0, AW'(5), 3, W'(18'h2A5A5));
    read_latency(1, AW'(300), 2, pat(300));

    // T2: credit stall with consumer stopped, ordered release
    for (int i = 0; i < 6; i++) send(0, 1'b1, AW'(i), W'(i), w);
    idle(0);
    drain(0);
    log_clear(0);
    rsp_ready[0] = 1'b0;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, AW'(i), '0, w);
      stall += w;
    end
    chk(0, "t2_first4_no_stall", 32'(stall), 32'd0);
    req_addr[0] = AW'(4);
    hi = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready[0]) hi++;
    end
    chk(0, "t2_ready_low_when_out_of_credit", 32'(hi), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready[0] = 1'b1;
    send(0, 1'b0, AW'(4), '0, w);
    send(0, 1'b0, AW'(5), '0, w);
    idle(0);
    drain(0);
    chk(0, "t2_rsp_count", 32'(log_size(0)), 32'd6);
    for (int i = 0; i < 6; i++) chk(0, "t2_rsp_order", 32'(log_at(0, i)), 32'(i));

    // T3: LOW_LATENCY, 100 back-to-back reads
    log_clear(1);
    stall = 0;
    for (int i = 0; i < 100; i++) begin
      send(1, 1'b0, AW'(100 + i), '0, w);
      stall += w;
    end
    idle(1);
    drain(1);
    chk(1, "t3_no_stall", 32'(stall), 32'd0);
    chk(1, "t3_rsp_count", 32'(log_size(1)), 32'd100);
    chk(1, "t3_first", 32'(log_at(1, 0)), 32'(pat(100)));
    chk(1, "t3_last", 32'(log_at(1, 99)), 32'(pat(199)));

    // T4: last entry write then immediate read
    log_clear(0);
    send(0, 1'b1, AW'(1023), W'(18'h3FFFF), w);
    send(0, 1'b0, AW'(1023), '0, w);
    idle(0);
    drain(0);
    chk(0, "t4_last_entry", 32'(log_at(0, log_size(0) - 1)), 32'h3FFFF);

    // T5: reset with 2 reads in flight and 2 FIFO entries
    rsp_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) send(0, 1'b0, AW'(10 + i), '0, w);
    idle(0);
    chk(0, "t5_prefill_valid", 32'(rsp_valid[0]), 32'd1);
    rst = 1'b1;
    #1;
    chk(0, "t5_rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk(0, "t5_rst_rsp_rdata", 32'(rsp_rdata[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_ready[0] = 1'b1;
    log_clear(0);
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b0, AW'(20 + i), '0, w);
      stall += w;
    end
    idle(0);
    drain(0);
    chk(0, "t5_no_stall", 32'(stall), 32'd0);
    chk(0, "t5_rsp_count", 32'(log_size(0)), 32'd4);
    chk(0, "t5_first", 32'(log_at(0, 0)), 32'(pat(20)));
    chk(0, "t5_last", 32'(log_at(0, 3)), 32'(pat(23)));

`ifdef TDP_RAM_PORT_ADAPTER_WRITE_ACK_EN
    // T6: write acknowledge returns old contents
    log_clear(0);
    send(0, 1'b1, AW'(7), W'(18'h00011), w);
    send(0, 1'b1, AW'(7), W'(18'h00022), w);
    send(0, 1'b0, AW'(7), '0, w);
    idle(0);
    drain(0);
    chk(0, "t6_rsp_count", 32'(log_size(0)), 32'd3);
    chk(0, "t6_write_ack_old", 32'(log_at(0, 1)), 32'h00011);
    chk(0, "t6_read_new", 32'(log_at(0, 2)), 32'h00022);
`endif

    drain(0);
    drain(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
